// File: rtl/link_tx.sv
// Link transmitter for one wormhole router output port: drains a FWFT buffer onto the link
// under credit flow control and marks the head and tail flit of each packet.
//   state | meaning
//   IDLE  | next flit sent is a head; its LEN field sizes the packet
//   BODY  | packet in progress; r_remaining flits still to send, the last one is the tail
module link_tx #(
  parameter int BUFFER_SIZE = 16,
  parameter int FLIT_WIDTH  = 64,
  localparam int CW         = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  input  logic                  empty_i,
  output logic                  pop_o,
  output logic [FLIT_WIDTH-1:0] flit_o,
  output logic                  valid_o,
  output logic                  head_o,
  output logic                  tail_o,
  input  logic                  credit_i,
  output logic [CW-1:0]         credits_o,
  output logic                  busy_o,
  output logic                  credit_err_o
);

  localparam logic [CW-1:0] CRED_MAX = CW'(BUFFER_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_remaining;
  logic [3:0]            w_remaining_nxt;
  logic [CW-1:0]         r_credits;
  logic [CW-1:0]         w_credits_nxt;
  logic                  r_credit_err;
  logic                  w_err_set;
  logic [FLIT_WIDTH-1:0] r_flit;
  logic                  r_valid;
  logic                  r_head;
  logic                  r_tail;
  logic                  w_send;
  logic                  w_head;
  logic                  w_tail;
  logic [3:0]            w_len;

  // pop depends only on registered credits, so a returning credit enables a send next cycle
  assign w_send = !empty_i && (r_credits != '0) && !rst;
  assign w_len  = flit_i[FLIT_WIDTH-5:FLIT_WIDTH-8];

  always_comb begin
    w_credits_nxt = r_credits;
    w_err_set     = 1'b0;
    case ({w_send, credit_i})
      2'b10: w_credits_nxt = r_credits - 1'b1;
      2'b01: begin
        if (r_credits == CRED_MAX) begin
          w_err_set = 1'b1;
        end else begin
          w_credits_nxt = r_credits + 1'b1;
        end
      end
      default: w_credits_nxt = r_credits;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_head          = 1'b0;
    w_tail          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_send) begin
          w_head = 1'b1;
          if (w_len == 4'd0) begin
            w_tail = 1'b1;
          end else begin
            w_remaining_nxt = w_len;
            w_state_nxt     = BODY;
          end
        end
      end
      BODY: begin
        if (w_send) begin
          w_remaining_nxt = r_remaining - 4'd1;
          if (r_remaining == 4'd1) begin
            w_tail      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_remaining  <= 4'd0;
      r_credits    <= CRED_MAX;
      r_credit_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_credits    <= w_credits_nxt;
      r_credit_err <= r_credit_err | w_err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flit  <= '0;
      r_valid <= 1'b0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      r_valid <= w_send;
      r_head  <= w_head;
      r_tail  <= w_tail;
      if (w_send) begin
        r_flit <= flit_i;
      end
    end
  end

  assign pop_o        = w_send;
  assign flit_o       = r_flit;
  assign valid_o      = r_valid;
  assign head_o       = r_head;
  assign tail_o       = r_tail;
  assign credits_o    = r_credits;
  assign busy_o       = (r_state == BODY);
  assign credit_err_o = r_credit_err;

endmodule

// File: tb/tb_link_tx.sv
// Scoreboarded bench for link_tx: stimulus queues flits and expected link words,
// a negedge monitor pops and compares every valid_o cycle.
module tb_link_tx;

  localparam int BS = 16;
  localparam int FW = 64;
  localparam int CW = $clog2(BS + 1);

  typedef struct {
    logic [FW-1:0] f;
    logic          h;
    logic          t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] flit_i;
  logic          empty_i;
  logic          pop_o;
  logic [FW-1:0] flit_o;
  logic          valid_o;
  logic          head_o;
  logic          tail_o;
  logic          credit_i;
  logic [CW-1:0] credits_o;
  logic          busy_o;
  logic          credit_err_o;

  logic [FW-1:0] up_q[$];
  exp_t          exp_q[$];
  logic          stall;
  int            n_total = 0;
  int            n_bad   = 0;
  int            n_valid = 0;

  link_tx #(.BUFFER_SIZE(BS), .FLIT_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .flit_i(flit_i), .empty_i(empty_i), .pop_o(pop_o),
    .flit_o(flit_o), .valid_o(valid_o), .head_o(head_o), .tail_o(tail_o),
    .credit_i(credit_i), .credits_o(credits_o), .busy_o(busy_o),
    .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [3:0] len, input logic [55:0] pay);
    return {2'b01, 2'b10, len, pay};
  endfunction

  task automatic apply();
    flit_i  = (up_q.size() != 0) ? up_q[0] : '0;
    empty_i = (up_q.size() == 0) || stall;
  endtask

  task automatic push(input logic [FW-1:0] f, input logic h, input logic t);
    exp_t e;
    e.f = f; e.h = h; e.t = t;
    up_q.push_back(f);
    exp_q.push_back(e);
    apply();
  endtask

  // one clock: pop the upstream model if the DUT popped, then release credit_i
  task automatic tick();
    logic p;
    @(negedge clk);
    p = pop_o;
    @(posedge clk);
    #1;
    if (p && up_q.size() != 0) void'(up_q.pop_front());
    credit_i = 1'b0;
    apply();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    stall    = 1'b0;
    credit_i = 1'b0;
    up_q.delete();
    exp_q.delete();
    apply();
    tick();
    tick();
    rst = 1'b0;
    apply();
  endtask

  always @(negedge clk) begin
    if (!rst && valid_o) begin
      exp_t e;
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("mon_flit", flit_o, e.f);
        chk("mon_head", {63'd0, head_o}, {63'd0, e.h});
        chk("mon_tail", {63'd0, tail_o}, {63'd0, e.t});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int guard;
    do_reset();
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_head", {63'd0, head_o}, 64'd0);
    chk("rst_tail", {63'd0, tail_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_err", {63'd0, credit_err_o}, 64'd0);
    chk("rst_flit", flit_o, 64'd0);
    chk("rst_credits", 64'(credits_o), 64'd16);

    // single-flit packet
    v0 = n_valid;
    push(mk(4'd0, 56'hA5), 1'b1, 1'b1);
    tick();
    chk("t1_credits", 64'(credits_o), 64'd15);
    chk("t1_busy", {63'd0, busy_o}, 64'd0);
    tick();
    chk("t1_valid_drop", {63'd0, valid_o}, 64'd0);
    chk("t1_nvalid", 64'(n_valid - v0), 64'd1);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // 4-flit packet, back-to-back
    do_reset();
    v0 = n_valid;
    push(mk(4'd3, 56'h111), 1'b1, 1'b0);
    push(64'h222, 1'b0, 1'b0);
    push(64'h333, 1'b0, 1'b0);
    push(64'h444, 1'b0, 1'b1);
    tick(); chk("t2_busy1", {63'd0, busy_o}, 64'd1);
    tick(); chk("t2_busy2", {63'd0, busy_o}, 64'd1);
    tick(); chk("t2_busy3", {63'd0, busy_o}, 64'd1);
    tick(); chk("t2_busy4", {63'd0, busy_o}, 64'd0);
    chk("t2_credits", 64'(credits_o), 64'd12);
    tick();
    chk("t2_nvalid", 64'(n_valid - v0), 64'd4);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // credit exhaustion
    do_reset();
    for (int i = 0; i < 20; i++) push(mk(4'd0, 56'(i + 1)), 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) tick();
    chk("t3_pop_zero", {63'd0, pop_o}, 64'd0);
    chk("t3_credits0", 64'(credits_o), 64'd0);
    chk("t3_left", 64'(up_q.size()), 64'd4);
    tick(); tick(); tick();
    chk("t3_still_left", 64'(up_q.size()), 64'd4);
    credit_i = 1'b1;
    tick();
    chk("t3_credit1", 64'(credits_o), 64'd1);
    chk("t3_pop_after_credit", {63'd0, pop_o}, 64'd1);
    chk("t3_left_after_credit", 64'(up_q.size()), 64'd4);
    tick();
    chk("t3_one_send", 64'(up_q.size()), 64'd3);
    chk("t3_credits_back0", 64'(credits_o), 64'd0);
    chk("t3_pop_zero2", {63'd0, pop_o}, 64'd0);
    guard = 0;
    while (up_q.size() != 0 && guard < 20) begin
      credit_i = 1'b1;
      tick();
      guard++;
    end
    chk("t3_drain_bound", 64'(up_q.size()), 64'd0);
    tick(); tick();
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // simultaneous send and credit, then overflow
    do_reset();
    for (int i = 0; i < 11; i++) push(mk(4'd0, 56'(i + 100)), 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    chk("t4_credits5", 64'(credits_o), 64'd5);
    push(mk(4'd0, 56'hBEEF), 1'b1, 1'b1);
    credit_i = 1'b1;
    tick();
    chk("t4_send_and_credit", 64'(credits_o), 64'd5);
    for (int i = 0; i < 11; i++) begin
      credit_i = 1'b1;
      tick();
    end
    chk("t4_credits16", 64'(credits_o), 64'd16);
    chk("t4_err_clear", {63'd0, credit_err_o}, 64'd0);
    credit_i = 1'b1;
    tick();
    chk("t4_saturate", 64'(credits_o), 64'd16);
    chk("t4_err_set", {63'd0, credit_err_o}, 64'd1);
    tick(); tick();
    chk("t4_err_sticky", {63'd0, credit_err_o}, 64'd1);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);
    do_reset();
    chk("t4_err_rst", {63'd0, credit_err_o}, 64'd0);

    // stall mid-packet
    v0 = n_valid;
    push(mk(4'd5, 56'h500), 1'b1, 1'b0);
    push(64'h501, 1'b0, 1'b0);
    push(64'h502, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("t5_busy_pre", {63'd0, busy_o}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall_novalid", {63'd0, valid_o}, 64'd0);
      chk("t5_stall_busy", {63'd0, busy_o}, 64'd1);
    end
    push(64'h503, 1'b0, 1'b0);
    push(64'h504, 1'b0, 1'b0);
    push(64'h505, 1'b0, 1'b1);
    tick(); tick();
    chk("t5_busy_resume", {63'd0, busy_o}, 64'd1);
    tick();
    chk("t5_busy_end", {63'd0, busy_o}, 64'd0);
    chk("t5_credits", 64'(credits_o), 64'd10);
    tick();
    chk("t5_nvalid", 64'(n_valid - v0), 64'd6);
    chk("t5_drained", 64'(exp_q.size()), 64'd0);

    // reset mid-packet
    push(mk(4'd5, 56'h600), 1'b1, 1'b0);
    push(64'h601, 1'b0, 1'b0);
    tick(); tick();
    chk("t6_busy", {63'd0, busy_o}, 64'd1);
    tick();
    do_reset();
    chk("t6_rst_valid", {63'd0, valid_o}, 64'd0);
    chk("t6_rst_head", {63'd0, head_o}, 64'd0);
    chk("t6_rst_tail", {63'd0, tail_o}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("t6_rst_flit", flit_o, 64'd0);
    chk("t6_rst_credits", 64'(credits_o), 64'd16);
    push(mk(4'd0, 56'h777), 1'b1, 1'b1);
    tick();
    chk("t6_head_after_rst", {63'd0, head_o}, 64'd1);
    chk("t6_busy_after", {63'd0, busy_o}, 64'd0);
    tick();
    chk("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
